// File: rtl/treat_jr.sv
// -----------------------------------------------------------------------------
// treat_jr -- return-address stack with JR target prediction and checking.
//
// JAL pushes its link address; JR pops the most recent one and presents it as
// the predicted target one cycle later. When the JR resolves, the real target
// is compared with the last prediction and a mispredict pulse is raised when
// they differ, or when nothing was predicted. On overflow the oldest entry is
// overwritten without notice. A flush clears the stack and any pending check.
//
// Ports
//   tr_i_clk         clock; all state changes on the rising edge
//   tr_i_rst_n       asynchronous active-low reset
//   tr_i_flush       synchronous clear; highest priority
//   tr_i_jal/ra      push request and the return address to push
//   tr_i_jr          pop request
//   tr_i_chk/rs      JR resolved and its actual target
//   tr_o_pred_pc     predicted JR target (registered)
//   tr_o_pred_valid  one-cycle pulse: tr_o_pred_pc is valid
//   tr_o_underflow   one-cycle pulse: pop attempted on an empty stack
//   tr_o_mispredict  one-cycle pulse: resolved target did not match
//   tr_o_count       number of valid entries (0..DEPTH)
//   tr_o_empty/full  decoded from tr_o_count
// -----------------------------------------------------------------------------
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module treat_jr #(
   parameter int DEPTH = 8,
   parameter int PC_W  = `PC_WIDTH
) (
   input  logic                     tr_i_clk,
   input  logic                     tr_i_rst_n,
   input  logic                     tr_i_flush,
   input  logic                     tr_i_jal,
   input  logic [PC_W-1:0]          tr_i_ra,
   input  logic                     tr_i_jr,
   input  logic                     tr_i_chk,
   input  logic [PC_W-1:0]          tr_i_rs,
   output logic [PC_W-1:0]          tr_o_pred_pc,
   output logic                     tr_o_pred_valid,
   output logic                     tr_o_underflow,
   output logic                     tr_o_mispredict,
   output logic [$clog2(DEPTH):0]   tr_o_count,
   output logic                     tr_o_empty,
   output logic                     tr_o_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_SWAP = 2'b11   // push and pop together
   } op_e;

   logic [PC_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] tp;
   logic [CNT_W-1:0] count;
   logic             pending;
   logic [PC_W-1:0]  last_pred;

   logic [PTR_W-1:0] top_idx;
   logic             has_entry;
   logic             pred_fire;
   logic [PC_W-1:0]  pop_val;
   op_e              op;

   assign op        = op_e'({tr_i_jal, tr_i_jr});
   assign top_idx   = tp - PTR_W'(1);   // wraps modulo DEPTH
   assign has_entry = (count != '0);

   // A pop yields a prediction when the stack holds something, or when a
   // push in the same cycle can be bypassed straight to the output.
   assign pred_fire = tr_i_jr & (has_entry | tr_i_jal);
   assign pop_val   = has_entry ? mem[top_idx] : tr_i_ra;

   assign tr_o_count = count;
   assign tr_o_empty = (count == '0);
   assign tr_o_full  = (count == FULL_CNT);

   always_ff @(posedge tr_i_clk or negedge tr_i_rst_n) begin
      if (!tr_i_rst_n) begin
         // NOTE: the storage array is reset too, because reset must leave every
         // entry at zero; this costs a reset net per bit of the array.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         tp              <= '0;
         count           <= '0;
         pending         <= 1'b0;
         last_pred       <= '0;
         tr_o_pred_pc    <= '0;
         tr_o_pred_valid <= 1'b0;
         tr_o_underflow  <= 1'b0;
         tr_o_mispredict <= 1'b0;
      end else if (tr_i_flush) begin
         // Flush wins over everything issued in the same cycle; stored data
         // and the last prediction value are left as they are.
         tp              <= '0;
         count           <= '0;
         pending         <= 1'b0;
         tr_o_pred_valid <= 1'b0;
         tr_o_underflow  <= 1'b0;
         tr_o_mispredict <= 1'b0;
      end else begin
         tr_o_pred_valid <= pred_fire;
         tr_o_underflow  <= tr_i_jr & ~tr_i_jal & ~has_entry;

         // The check always looks at the pre-edge pending/last_pred, so a
         // prediction made in the same cycle only affects the next check.
         tr_o_mispredict <= tr_i_chk & (~pending | (tr_i_rs != last_pred));

         if (pred_fire) begin
            pending   <= 1'b1;
            last_pred <= pop_val;
         end else if (tr_i_chk) begin
            pending   <= 1'b0;
         end

         unique case (op)
            OP_PUSH: begin
               // When full, tp already points at the oldest entry, so the
               // write overwrites it and the count saturates.
               mem[tp] <= tr_i_ra;
               tp      <= tp + PTR_W'(1);
               if (count != FULL_CNT) count <= count + CNT_W'(1);
            end
            OP_POP: begin
               if (has_entry) begin
                  tr_o_pred_pc <= mem[top_idx];
                  tp           <= top_idx;
                  count        <= count - CNT_W'(1);
               end
            end
            OP_SWAP: begin
               // Replace the top entry in place; depth does not change.
               tr_o_pred_pc <= pop_val;
               if (has_entry) mem[top_idx] <= tr_i_ra;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/treat_jr.md
TREAT_JR -- requirements
Module: treat_jr

Interface
REQ-001 The block SHALL be clocked by a single clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter DEPTH: default 8; number of return-address entries; power of two, at least 2.
REQ-003 Parameter PC_W: default `PC_WIDTH (32); width of every address.
REQ-004 tr_i_clk  input  1  single clock; all state updates on the rising edge.
REQ-005 tr_i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 tr_i_flush  input  1  synchronous stack/prediction clear (pipeline flush).
REQ-007 tr_i_jal  input  1  push request; the JAL issued this cycle.
REQ-008 tr_i_ra  input  PC_W  return address to push (JAL link value).
REQ-009 tr_i_jr  input  1  pop request; the JR issued this cycle.
REQ-010 tr_i_chk  input  1  JR resolved; the actual target is on tr_i_rs.
REQ-011 tr_i_rs  input  PC_W  actual JR target read from the register file.
REQ-012 tr_o_pred_pc  output  PC_W  predicted JR target, registered.
REQ-013 tr_o_pred_valid  output  1  tr_o_pred_pc is valid this cycle; one-cycle pulse.
REQ-014 tr_o_underflow  output  1  one-cycle pulse when a pop is attempted on an empty stack.
REQ-015 tr_o_mispredict  output  1  one-cycle pulse when a check fails.
REQ-016 tr_o_count  output  clog2(DEPTH)+1  number of valid entries.
REQ-017 tr_o_empty / tr_o_full  output  1 each  empty is count==0; full is count==DEPTH; both combinational from count.

Function
REQ-018 Storage SHALL be a circular array mem[0..DEPTH-1] with top pointer tp (clog2(DEPTH) bits) that wraps modulo DEPTH.
REQ-019 Push only: mem[tp] <= tr_i_ra; tp <= tp+1; count <= min(count+1, DEPTH).
REQ-020 Push while full: the oldest entry SHALL be overwritten silently and count SHALL stay DEPTH.
REQ-021 Pop only with count>0:
- tr_o_pred_pc <= mem[tp-1]; tp <= tp-1; count <= count-1.
- tr_o_pred_valid = 1 in the next cycle (latency 1).
REQ-022 Pop only with count==0:
- tr_o_pred_valid stays 0; tp, count and tr_o_pred_pc are unchanged.
- tr_o_underflow = 1 in the next cycle.
REQ-023 Push and pop in the same cycle with count>0:
- tr_o_pred_pc <= old mem[tp-1], and mem[tp-1] <= tr_i_ra.
- tp and count are unchanged; tr_o_pred_valid = 1 next cycle.
REQ-024 Push and pop in the same cycle with count==0: tr_o_pred_pc <= tr_i_ra (bypass); tr_o_pred_valid = 1; the stack stays empty; no underflow.
REQ-025 Every valid prediction SHALL load an internal last_pred register and set a pending flag.
REQ-026 tr_i_chk with pending=1:
- tr_o_mispredict <= (tr_i_rs != last_pred) next cycle.
- pending is cleared.
REQ-027 tr_i_chk with pending=0: tr_o_mispredict <= 1 next cycle.
REQ-028 tr_i_chk and a valid pop in the same cycle: the check SHALL use the pre-edge last_pred/pending, and the pop SHALL then set a new last_pred with pending=1.
REQ-029 tr_i_flush SHALL have the highest priority:
- tp, count, pending, tr_o_pred_valid, tr_o_underflow and tr_o_mispredict are cleared at the edge.
- jal/jr/chk in the same cycle are ignored.
- mem contents are not required to be cleared.
REQ-030 Pulse outputs (pred_valid, underflow, mispredict) SHALL be 0 in any cycle not caused by an event on the previous edge.

Reset
REQ-031 While tr_i_rst_n=0, independent of the clock:
- tp=0, count=0, pending=0, last_pred=0 and all mem entries 0.
- tr_o_pred_pc=0, tr_o_pred_valid=0, tr_o_underflow=0, tr_o_mispredict=0.
- tr_o_empty=1 and tr_o_full=0.
REQ-032 Reset asserted mid-operation SHALL discard all entries and any pending check; the first edge after deassertion SHALL behave as from an empty stack.

Verification (DEPTH=4, PC_W=32)
REQ-033 Push 0x14, 0x28, 0x3C, then pop x3 -> pred_pc 0x3C, 0x28, 0x14, each with pred_valid one cycle after its jr; count 3->0; empty=1.
REQ-034 Push 0x10, 0x20, 0x30, 0x40, 0x50 (overflow), then pop x4 -> pred_pc 0x50, 0x40, 0x30, 0x20; full stays 1 during the 5th push; a 5th pop gives underflow=1 and pred_valid=0.
REQ-035 With stack {0x100}, jal (ra 0x200) and jr together -> pred_pc 0x100, count stays 1; next pop -> 0x200. On an empty stack, jal (ra 0x44) and jr together -> pred_pc 0x44, count 0.
REQ-036 Pop giving 0x80, then chk with rs=0x80 -> mispredict 0; pop giving 0x90, then chk with rs=0x94 -> mispredict 1; chk with nothing pending -> mispredict 1.
REQ-037 Push x2 then flush together with jal -> count 0, no push; then pop -> underflow 1.
REQ-038 Drop tr_i_rst_n asynchronously mid-pop -> outputs 0 immediately; after release, pop -> underflow 1.
